// File: rtl/execute_stage.sv
// execute_stage: Decode->Execute pipeline register plus the Execute datapath.
// The register stage captures the control word, operands and register indices.
// Forwarding muxes pick the operands feeding an 8-bit scalar ALU and a
// 16-lane x 8-bit vector ALU. Both ALUs are combinational.
// Optional build macro ALU_FLAGS_EN adds the alu_zero and alu_carry outputs.
module execute_stage #(
  parameter int DATA_W = 16,
  parameter int VEC_W  = 128,
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [19:0]       ctrl_in,
  input  logic [DATA_W-1:0] srcA_in,
  input  logic [DATA_W-1:0] srcB_in,
  input  logic [VEC_W-1:0]  srcA_vector_in,
  input  logic [VEC_W-1:0]  srcB_vector_in,
  input  logic [4:0]        rs1_decode,
  input  logic [4:0]        rs2_decode,
  input  logic [4:0]        rd_decode,
  input  logic [2:0]        select_forward_mux_A,
  input  logic [2:0]        select_forward_mux_B,
  input  logic [DATA_W-1:0] fwd_wb_data,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic [VEC_W-1:0]  fwd_wb_vector,
  input  logic [VEC_W-1:0]  fwd_mem_vector,
  output logic              wre_execute,
  output logic              vector_wre_execute,
  output logic              write_memory_enable_a_execute,
  output logic              write_memory_enable_b_execute,
  output logic [1:0]        select_writeback_data_mux_execute,
  output logic [1:0]        select_writeback_vector_data_mux_execute,
  output logic [4:0]        aluOp_execute,
  output logic [4:0]        aluVectorOp_execute,
  output logic              load_instruction,
  output logic [DATA_W-1:0] srcA_execute,
  output logic [DATA_W-1:0] srcB_execute,
  output logic [DATA_W-1:0] srcB_fwd,
  output logic [VEC_W-1:0]  vector_srcA_execute,
  output logic [VEC_W-1:0]  vector_srcB_execute,
  output logic [4:0]        rs1_execute,
  output logic [4:0]        rs2_execute,
  output logic [4:0]        rd_execute,
  output logic [7:0]        alu_result_execute,
  output logic [VEC_W-1:0]  alu_vector_result_execute
`ifdef ALU_FLAGS_EN
  ,
  output logic              alu_zero,
  output logic              alu_carry
`endif
);

  localparam int LANES = VEC_W / LANE_W;

  // Bit 0 of the control word is reserved and never stored.
  logic [19:1]       ctrl_q;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [VEC_W-1:0]  vfwd_a;
  logic [VEC_W-1:0]  vfwd_b;

  // One lane of ALU: shared by the scalar path and every vector lane.
  function automatic logic [LANE_W-1:0] alu_lane(input logic [4:0] op,
                                                 input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
    logic [LANE_W-1:0] r;
    r = '0;
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = a << b[2:0];
      5'd6: r = a >> b[2:0];
      5'd7: r = a * b;
      5'd8: r = a;
      5'd9: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Decode->Execute register; a bubble is simply an all-zero control word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q              <= '0;
      srcA_execute        <= '0;
      srcB_execute        <= '0;
      vector_srcA_execute <= '0;
      vector_srcB_execute <= '0;
      rs1_execute         <= '0;
      rs2_execute         <= '0;
      rd_execute          <= '0;
    end else begin
      ctrl_q              <= ctrl_in[19:1];
      srcA_execute        <= srcA_in;
      srcB_execute        <= srcB_in;
      vector_srcA_execute <= srcA_vector_in;
      vector_srcB_execute <= srcB_vector_in;
      rs1_execute         <= rs1_decode;
      rs2_execute         <= rs2_decode;
      rd_execute          <= rd_decode;
    end
  end

  assign wre_execute                              = ctrl_q[19];
  assign vector_wre_execute                       = ctrl_q[18];
  assign write_memory_enable_a_execute            = ctrl_q[17];
  assign write_memory_enable_b_execute            = ctrl_q[16];
  assign select_writeback_data_mux_execute        = ctrl_q[15:14];
  assign select_writeback_vector_data_mux_execute = ctrl_q[13:12];
  assign aluOp_execute                            = ctrl_q[11:7];
  assign aluVectorOp_execute                      = ctrl_q[6:2];
  assign load_instruction                         = ctrl_q[1];

  // Forwarding muxes: 1 = writeback, 2 = memory, anything else = registered operand.
  always_comb begin
    fwd_a  = srcA_execute;
    fwd_b  = srcB_execute;
    vfwd_a = vector_srcA_execute;
    vfwd_b = vector_srcB_execute;
    if (select_forward_mux_A == 3'd1) begin
      fwd_a  = fwd_wb_data;
      vfwd_a = fwd_wb_vector;
    end else if (select_forward_mux_A == 3'd2) begin
      fwd_a  = fwd_mem_data;
      vfwd_a = fwd_mem_vector;
    end
    if (select_forward_mux_B == 3'd1) begin
      fwd_b  = fwd_wb_data;
      vfwd_b = fwd_wb_vector;
    end else if (select_forward_mux_B == 3'd2) begin
      fwd_b  = fwd_mem_data;
      vfwd_b = fwd_mem_vector;
    end
  end

  assign srcB_fwd = fwd_b;

  // The scalar ALU only looks at the low byte of each operand.
  assign alu_result_execute = alu_lane(aluOp_execute, fwd_a[7:0], fwd_b[7:0]);

  // Vector ALU: lanes are fully independent, so no carry or borrow can leak.
  always_comb begin
    alu_vector_result_execute = '0;
    for (int i = 0; i < LANES; i++) begin
      alu_vector_result_execute[i*LANE_W +: LANE_W] =
        alu_lane(aluVectorOp_execute, vfwd_a[i*LANE_W +: LANE_W], vfwd_b[i*LANE_W +: LANE_W]);
    end
  end

  // The upper bits of forwarded A and the reserved control bit have no consumer.
  logic unused_bits;
  assign unused_bits = ^{ctrl_in[0], fwd_a[DATA_W-1:8]};

`ifdef ALU_FLAGS_EN
  logic [8:0] add_wide;
  assign add_wide = {1'b0, fwd_a[7:0]} + {1'b0, fwd_b[7:0]};

  // Flags follow the scalar result; carry is meaningful for ADD/SUB only.
  always_comb begin
    alu_zero  = (alu_result_execute == 8'd0);
    alu_carry = 1'b0;
    if (aluOp_execute == 5'd0)
      alu_carry = add_wide[8];
    else if (aluOp_execute == 5'd1)
      alu_carry = (fwd_a[7:0] < fwd_b[7:0]);
  end
`endif

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [19:0]  ctrl_in = '0;
  logic [15:0]  srcA_in = '0, srcB_in = '0;
  logic [127:0] srcA_vector_in = '0, srcB_vector_in = '0;
  logic [4:0]   rs1_decode = '0, rs2_decode = '0, rd_decode = '0;
  logic [2:0]   select_forward_mux_A = '0, select_forward_mux_B = '0;
  logic [15:0]  fwd_wb_data = '0, fwd_mem_data = '0;
  logic [127:0] fwd_wb_vector = '0, fwd_mem_vector = '0;

  logic         wre_execute, vector_wre_execute;
  logic         write_memory_enable_a_execute, write_memory_enable_b_execute;
  logic [1:0]   select_writeback_data_mux_execute, select_writeback_vector_data_mux_execute;
  logic [4:0]   aluOp_execute, aluVectorOp_execute;
  logic         load_instruction;
  logic [15:0]  srcA_execute, srcB_execute, srcB_fwd;
  logic [127:0] vector_srcA_execute, vector_srcB_execute;
  logic [4:0]   rs1_execute, rs2_execute, rd_execute;
  logic [7:0]   alu_result_execute;
  logic [127:0] alu_vector_result_execute;
`ifdef ALU_FLAGS_EN
  logic         alu_zero, alu_carry;
`endif

  int checks = 0;
  int failures = 0;

  execute_stage dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in),
    .srcA_in(srcA_in), .srcB_in(srcB_in),
    .srcA_vector_in(srcA_vector_in), .srcB_vector_in(srcB_vector_in),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode),
    .select_forward_mux_A(select_forward_mux_A), .select_forward_mux_B(select_forward_mux_B),
    .fwd_wb_data(fwd_wb_data), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_vector(fwd_wb_vector), .fwd_mem_vector(fwd_mem_vector),
    .wre_execute(wre_execute), .vector_wre_execute(vector_wre_execute),
    .write_memory_enable_a_execute(write_memory_enable_a_execute),
    .write_memory_enable_b_execute(write_memory_enable_b_execute),
    .select_writeback_data_mux_execute(select_writeback_data_mux_execute),
    .select_writeback_vector_data_mux_execute(select_writeback_vector_data_mux_execute),
    .aluOp_execute(aluOp_execute), .aluVectorOp_execute(aluVectorOp_execute),
    .load_instruction(load_instruction),
    .srcA_execute(srcA_execute), .srcB_execute(srcB_execute), .srcB_fwd(srcB_fwd),
    .vector_srcA_execute(vector_srcA_execute), .vector_srcB_execute(vector_srcB_execute),
    .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
    .alu_result_execute(alu_result_execute),
    .alu_vector_result_execute(alu_vector_result_execute)
`ifdef ALU_FLAGS_EN
    , .alu_zero(alu_zero), .alu_carry(alu_carry)
`endif
  );

  always #5 clk = ~clk;

  // All control outputs gathered in ctrl_in[19:1] field order.
  logic [18:0] ctrl_out;
  assign ctrl_out = {wre_execute, vector_wre_execute, write_memory_enable_a_execute,
                     write_memory_enable_b_execute, select_writeback_data_mux_execute,
                     select_writeback_vector_data_mux_execute, aluOp_execute,
                     aluVectorOp_execute, load_instruction};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on one byte, from the opcode table.
  function automatic logic [7:0] ref_op(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a * (1 << (b % 8))) % 256;
      6: r = a / (1 << (b % 8));
      7: r = (a * b) % 256;
      8: r = a;
      9: r = b;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  function automatic logic [127:0] ref_vec(input int op, input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = ref_op(op, int'(a[8*i +: 8]), int'(b[8*i +: 8]));
    return r;
  endfunction

  function automatic logic [15:0] ref_fwd(input int sel, input logic [15:0] r, input logic [15:0] wb, input logic [15:0] mem);
    return (sel == 1) ? wb : (sel == 2) ? mem : r;
  endfunction

  function automatic logic [127:0] ref_vfwd(input int sel, input logic [127:0] r, input logic [127:0] wb, input logic [127:0] mem);
    return (sel == 1) ? wb : (sel == 2) ? mem : r;
  endfunction

  task automatic capture();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0]  a, b, fa, fb;
    logic [127:0] va, vb;
    int           op, vop;

    // Reset state
    #12;
    chk("reset_ctrl", 128'(ctrl_out), 128'd0);
    chk("reset_alu", 128'(alu_result_execute), 128'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Control decode
    ctrl_in = 20'h80000;
    capture();
    chk("decode_wre", 128'(ctrl_out), 128'(19'h40000));
    ctrl_in = 20'h00382;
    capture();
    chk("decode_aluop", 128'(aluOp_execute), 128'd7);
    chk("decode_load", 128'(load_instruction), 128'd1);
    chk("decode_rest", 128'({ctrl_out[18:11], ctrl_out[5:1]}), 128'd0);

    // Scalar ALU, registered operands
    ctrl_in = 20'(0 << 7); srcA_in = 16'h007F; srcB_in = 16'h0002;
    capture();
    chk("alu_add", 128'(alu_result_execute), 128'h81);
    ctrl_in = 20'(1 << 7); srcA_in = 16'h0005; srcB_in = 16'h0007;
    capture();
    chk("alu_sub", 128'(alu_result_execute), 128'hFE);
    ctrl_in = 20'(5 << 7); srcA_in = 16'h0081; srcB_in = 16'h0003;
    capture();
    chk("alu_sll", 128'(alu_result_execute), 128'h08);

    // Forwarding
    ctrl_in = 20'(0 << 7); srcA_in = 16'h0001; srcB_in = 16'h0001;
    fwd_mem_data = 16'h0033; select_forward_mux_A = 3'd2;
    capture();
    chk("fwd_mem_add", 128'(alu_result_execute), 128'h34);
    select_forward_mux_A = 3'd5;
    #1;
    chk("fwd_sel5_add", 128'(alu_result_execute), 128'h02);
    select_forward_mux_A = 3'd0;

    // Vector: per-lane wrap without carry into neighbours
    ctrl_in = 20'(0 << 2);
    srcA_vector_in = {16{8'hFF}}; srcB_vector_in = {16{8'h01}};
    capture();
    chk("vec_add_wrap", alu_vector_result_execute, 128'd0);
    ctrl_in = 20'(4 << 2);
    srcA_vector_in = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
    srcB_vector_in = 128'h1111_1111_1111_1111_1111_1111_1111_1110;
    capture();
    chk("vec_xor_lane0", 128'(alu_vector_result_execute[7:0]), 128'd0);
    chk("vec_xor_all", alu_vector_result_execute, ref_vec(4, srcA_vector_in, srcB_vector_in));

    // Bubble
    ctrl_in = 20'h0; srcA_in = 16'hBEEF; srcB_in = 16'h1234; rd_decode = 5'd9;
    capture();
    chk("bubble_ctrl", 128'(ctrl_out), 128'd0);
    chk("bubble_srcA", 128'(srcA_execute), 128'hBEEF);
    chk("bubble_rd", 128'(rd_execute), 128'd9);

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      op  = int'($urandom_range(0, 12));
      vop = int'($urandom_range(0, 12));
      ctrl_in = 20'($urandom);
      ctrl_in[11:7] = 5'(op);
      ctrl_in[6:2]  = 5'(vop);
      a = 16'($urandom); b = 16'($urandom);
      va = {$urandom, $urandom, $urandom, $urandom};
      vb = {$urandom, $urandom, $urandom, $urandom};
      srcA_in = a; srcB_in = b; srcA_vector_in = va; srcB_vector_in = vb;
      rs1_decode = 5'($urandom); rs2_decode = 5'($urandom); rd_decode = 5'($urandom);
      select_forward_mux_A = 3'($urandom); select_forward_mux_B = 3'($urandom);
      fwd_wb_data = 16'($urandom); fwd_mem_data = 16'($urandom);
      fwd_wb_vector = {$urandom, $urandom, $urandom, $urandom};
      fwd_mem_vector = {$urandom, $urandom, $urandom, $urandom};
      capture();
      fa = ref_fwd(int'(select_forward_mux_A), a, fwd_wb_data, fwd_mem_data);
      fb = ref_fwd(int'(select_forward_mux_B), b, fwd_wb_data, fwd_mem_data);
      chk("rnd_ctrl", 128'(ctrl_out), 128'(ctrl_in[19:1]));
      chk("rnd_ops", 128'({srcA_execute, srcB_execute}), 128'({a, b}));
      chk("rnd_vops", vector_srcA_execute ^ vector_srcB_execute, va ^ vb);
      chk("rnd_vopA", vector_srcA_execute, va);
      chk("rnd_idx", 128'({rs1_execute, rs2_execute, rd_execute}),
          128'({rs1_decode, rs2_decode, rd_decode}));
      chk("rnd_srcB_fwd", 128'(srcB_fwd), 128'(fb));
      chk("rnd_alu", 128'(alu_result_execute), 128'(ref_op(op, int'(fa[7:0]), int'(fb[7:0]))));
      chk("rnd_valu", alu_vector_result_execute,
          ref_vec(vop,
                  ref_vfwd(int'(select_forward_mux_A), va, fwd_wb_vector, fwd_mem_vector),
                  ref_vfwd(int'(select_forward_mux_B), vb, fwd_wb_vector, fwd_mem_vector)));
`ifdef ALU_FLAGS_EN
      chk("rnd_zero", 128'(alu_zero), 128'(ref_op(op, int'(fa[7:0]), int'(fb[7:0])) == 8'd0));
      chk("rnd_carry", 128'(alu_carry),
          128'((op == 0) ? (int'(fa[7:0]) + int'(fb[7:0]) > 255) :
               (op == 1) ? (int'(fa[7:0]) < int'(fb[7:0])) : 1'b0));
`endif
    end

    // Mid-run asynchronous reset with non-zero state, checked before any edge
    ctrl_in = 20'hFFFFE; srcA_in = 16'hA5A5; srcB_in = 16'h5A5A;
    srcA_vector_in = {8{16'hABCD}}; srcB_vector_in = {8{16'h1357}};
    rs1_decode = 5'd3; rs2_decode = 5'd4; rd_decode = 5'd5;
    select_forward_mux_A = 3'd0; select_forward_mux_B = 3'd0;
    capture();
    chk("pre_reset_ctrl", 128'(ctrl_out), 128'(19'h7FFFF));
    #1;
    reset = 1'b1;
    #1;
    chk("areset_ctrl", 128'(ctrl_out), 128'd0);
    chk("areset_ops", 128'({srcA_execute, srcB_execute, srcB_fwd}), 128'd0);
    chk("areset_vops", vector_srcA_execute | vector_srcB_execute, 128'd0);
    chk("areset_idx", 128'({rs1_execute, rs2_execute, rd_execute}), 128'd0);
    chk("areset_alu", 128'(alu_result_execute), 128'd0);
    chk("areset_valu", alu_vector_result_execute, 128'd0);
    capture();
    chk("held_reset_ctrl", 128'(ctrl_out), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
